pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL: clk  in  1  single clock; all state on rising edge.
REQ-002 SHALL: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL: ID_rs, ID_rt  in  5 each  source registers of the instruction in ID.
REQ-004 SHALL: ID_RsRead, ID_RtRead  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL: EXE_Dst  in  5  destination register of the instruction in EXE.
REQ-006 SHALL: EXE_IsLoad, EXE_IsMFC0  in  1 each  EXE instruction is a load / MFC0.
REQ-007 SHALL: EXE_DivStart  in  1  a divide is in EXE; the divider needs 32 cycles.
REQ-008 SHALL: EXE_BranchMiss  in  1  branch misprediction resolved in EXE.
REQ-009 SHALL: ICache_Busy, DCache_Busy  in  1 each  fetch / memory access not yet complete.
REQ-010 SHALL: MEM_ExcValid  in  1  exception taken at MEM.
REQ-011 SHALL: PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr  out  1 each  stage-register write enables.
REQ-012 SHALL: ID_Flush, EXE_Flush, MEM_Flush, WB_Flush  out  1 each  stage-register flush (bubble insert).
REQ-013 SHALL: Div_Busy  out  1  divider FSM is in DIV_RUN; Div_Done  out  1  one-cycle completion strobe.
REQ-014 SHALL: Stall_Cnt  out  32  count of cycles with PC_Wr==0 (REQ-030).

Function
REQ-015 SHALL: all outputs are combinational from inputs and FSM state, except Div_Done and Stall_Cnt, which are registered.
REQ-016 SHALL: default (no event): all *_Wr=1, all *_Flush=0.
REQ-017 SHALL: load-use hazard = (EXE_IsLoad|EXE_IsMFC0) & EXE_Dst!=0 & ((ID_RsRead & ID_rs==EXE_Dst) | (ID_RtRead & ID_rt==EXE_Dst)).
REQ-018 SHALL: resolve one event per cycle, priority MEM_ExcValid > DCache_Busy > DIV_RUN > load-use > ICache_Busy > EXE_BranchMiss.
REQ-019 SHALL: MEM_ExcValid -> PC_Wr=1; ID_Flush=EXE_Flush=MEM_Flush=WB_Flush=1.
REQ-020 SHALL: DCache_Busy -> PC_Wr=ID_Wr=EXE_Wr=MEM_Wr=0; WB_Flush=1.
REQ-021 SHALL: DIV_RUN -> PC_Wr=ID_Wr=EXE_Wr=0; MEM_Flush=1.
REQ-022 SHALL: load-use -> PC_Wr=ID_Wr=0; EXE_Flush=1; exactly one bubble per hazard.
REQ-023 SHALL: ICache_Busy -> PC_Wr=0; ID_Flush=1.
REQ-024 SHALL: EXE_BranchMiss -> PC_Wr=1 (redirect); ID_Flush=1.
REQ-025 SHALL: divider FSM states IDLE, DIV_RUN, DIV_DONE; IDLE->DIV_RUN on EXE_DivStart with counter loaded to 31; DIV_RUN decrements every cycle DCache_Busy==0; at 0 -> DIV_DONE; DIV_DONE -> IDLE after one cycle, Div_Done=1 in that cycle; EXE_DivStart is ignored outside IDLE.
REQ-026 SHALL: in DIV_DONE, EXE_Wr=1 so the divide advances; a new EXE_DivStart is accepted only from IDLE, the cycle after DIV_DONE.
REQ-027 SHALL: MEM_ExcValid in any state aborts the divide: next state IDLE, counter 0, no Div_Done.
REQ-028 SHALL: any flush of a stage overrides its write enable (Flush=1 implies the register loads bubble regardless of *_Wr).

Reset
REQ-029 SHALL: on rst: FSM=IDLE, counter=0, Div_Done=0, Stall_Cnt=0; combinational outputs then follow REQ-016; reset asserted mid-divide aborts it immediately.

Configuration
REQ-030 SHALL: macro PIPE_STALL_CNT_EN defined -> Stall_Cnt increments by 1 each cycle PC_Wr==0 and is not in reset, wrapping 0xFFFFFFFF->0; undefined -> Stall_Cnt is tied to 0 with no counter logic; the port exists in both builds.

Verification
REQ-031 SHALL: EXE_IsLoad=1, EXE_Dst=5, ID_rs=5, ID_RsRead=1 -> one cycle PC_Wr=ID_Wr=0, EXE_Flush=1, then defaults.
REQ-032 SHALL: EXE_DivStart pulse -> Div_Busy=1 for 32 cycles with MEM_Flush=1, then Div_Done=1 for one cycle, then IDLE.
REQ-033 SHALL: MEM_ExcValid at DIV_RUN cycle 10 -> same cycle four flushes + PC_Wr=1; next cycle Div_Busy=0, no Div_Done.
REQ-034 SHALL: DCache_Busy for 3 cycles during DIV_RUN -> divide lasts 35 cycles; all Wr=0 in those 3 cycles.
REQ-035 SHALL: EXE_Dst=0 with matching ID_rs=0 -> no stall.
REQ-036 SHALL: with PIPE_STALL_CNT_EN, ICache_Busy held 7 cycles from reset -> Stall_Cnt=7; without it, Stall_Cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_if.sv
// Pipeline control bundle: hazard/event inputs from the datapath and
// stage write-enable / flush outputs back to it.
// master = datapath side (drives events), slave = pipe_ctrl.
interface pipe_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        ID_RsRead;
    logic        ID_RtRead;
    logic [4:0]  EXE_Dst;
    logic        EXE_IsLoad;
    logic        EXE_IsMFC0;
    logic        EXE_DivStart;
    logic        EXE_BranchMiss;
    logic        ICache_Busy;
    logic        DCache_Busy;
    logic        MEM_ExcValid;
    logic        PC_Wr;
    logic        ID_Wr;
    logic        EXE_Wr;
    logic        MEM_Wr;
    logic        WB_Wr;
    logic        ID_Flush;
    logic        EXE_Flush;
    logic        MEM_Flush;
    logic        WB_Flush;
    logic        Div_Busy;
    logic        Div_Done;
    logic [31:0] Stall_Cnt;

    modport master (
        output ID_rs, ID_rt, ID_RsRead, ID_RtRead, EXE_Dst, EXE_IsLoad,
               EXE_IsMFC0, EXE_DivStart, EXE_BranchMiss, ICache_Busy,
               DCache_Busy, MEM_ExcValid,
        input  PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush,
               MEM_Flush, WB_Flush, Div_Busy, Div_Done, Stall_Cnt
    );

    modport slave (
        input  ID_rs, ID_rt, ID_RsRead, ID_RtRead, EXE_Dst, EXE_IsLoad,
               EXE_IsMFC0, EXE_DivStart, EXE_BranchMiss, ICache_Busy,
               DCache_Busy, MEM_ExcValid,
        output PC_Wr, ID_Wr, EXE_Wr, MEM_Wr, WB_Wr, ID_Flush, EXE_Flush,
               MEM_Flush, WB_Flush, Div_Busy, Div_Done, Stall_Cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller with a 32-cycle divider sequencer.
// Resolves one event per cycle: exception > D-cache miss > divide running >
// load-use > I-cache miss > branch mispredict.
// Optional build macro PIPE_STALL_CNT_EN enables the PC-stall cycle counter;
// without it Stall_Cnt is constant zero.
module pipe_ctrl (
    input logic        clk,
    input logic        rst,
    pipe_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    div_state_t state;
    logic [4:0] cnt;
    logic       div_done;
    logic       load_use;

    logic pc_wr, id_wr, exe_wr, mem_wr, wb_wr;
    logic id_flush, exe_flush, mem_flush, wb_flush;

    // Load/MFC0 result consumed by the very next instruction; r0 never hazards.
    always_comb begin
        load_use = (bus.EXE_IsLoad | bus.EXE_IsMFC0) && (bus.EXE_Dst != 5'd0) &&
                   ((bus.ID_RsRead && (bus.ID_rs == bus.EXE_Dst)) ||
                    (bus.ID_RtRead && (bus.ID_rt == bus.EXE_Dst)));
    end

    // Priority-resolved write enables and flushes for the current cycle.
    always_comb begin
        pc_wr     = 1'b1;
        id_wr     = 1'b1;
        exe_wr    = 1'b1;
        mem_wr    = 1'b1;
        wb_wr     = 1'b1;
        id_flush  = 1'b0;
        exe_flush = 1'b0;
        mem_flush = 1'b0;
        wb_flush  = 1'b0;
        if (bus.MEM_ExcValid) begin
            id_flush  = 1'b1;
            exe_flush = 1'b1;
            mem_flush = 1'b1;
            wb_flush  = 1'b1;
        end else if (bus.DCache_Busy) begin
            pc_wr    = 1'b0;
            id_wr    = 1'b0;
            exe_wr   = 1'b0;
            mem_wr   = 1'b0;
            wb_flush = 1'b1;
        end else if (state == DIV_RUN) begin
            pc_wr     = 1'b0;
            id_wr     = 1'b0;
            exe_wr    = 1'b0;
            mem_flush = 1'b1;
        end else if (load_use) begin
            pc_wr     = 1'b0;
            id_wr     = 1'b0;
            exe_flush = 1'b1;
        end else if (bus.ICache_Busy) begin
            pc_wr    = 1'b0;
            id_flush = 1'b1;
        end else if (bus.EXE_BranchMiss) begin
            id_flush = 1'b1;
        end
    end

    // Divider sequencer: 32 counted cycles (frozen while D-cache is busy),
    // one DIV_DONE cycle with a registered completion strobe; exceptions abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            div_done <= 1'b0;
        end else if (bus.MEM_ExcValid) begin
            state    <= IDLE;
            cnt      <= '0;
            div_done <= 1'b0;
        end else begin
            div_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.EXE_DivStart) begin
                        state <= DIV_RUN;
                        cnt   <= 5'd31;
                    end
                end
                DIV_RUN: begin
                    if (!bus.DCache_Busy) begin
                        if (cnt == 5'd0) begin
                            state    <= DIV_DONE;
                            div_done <= 1'b1;
                        end else begin
                            cnt <= cnt - 5'd1;
                        end
                    end
                end
                DIV_DONE: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] stall_cnt;

    // Count cycles in which the PC is held; wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (!pc_wr) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign bus.Stall_Cnt = stall_cnt;
`else
    assign bus.Stall_Cnt = '0;
`endif

    assign bus.PC_Wr     = pc_wr;
    assign bus.ID_Wr     = id_wr;
    assign bus.EXE_Wr    = exe_wr;
    assign bus.MEM_Wr    = mem_wr;
    assign bus.WB_Wr     = wb_wr;
    assign bus.ID_Flush  = id_flush;
    assign bus.EXE_Flush = exe_flush;
    assign bus.MEM_Flush = mem_flush;
    assign bus.WB_Flush  = wb_flush;
    assign bus.Div_Busy  = (state == DIV_RUN);
    assign bus.Div_Done  = div_done;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Inputs are driven 1 time unit after the
// rising edge; expected output vectors are queued with the stimulus and
// compared at the following falling edge.
// Output vector bit order:
// {PC_Wr,ID_Wr,EXE_Wr,MEM_Wr,WB_Wr, ID_Flush,EXE_Flush,MEM_Flush,WB_Flush, Div_Busy,Div_Done}
module tb_pipe_ctrl;

    logic clk;
    logic rst;

    pipe_ctrl_if bus ();

    pipe_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic       rst;
        logic       exc;
        logic       dcb;
        logic       icb;
        logic       br;
        logic       div;
        logic       ld;
        logic       mfc0;
        logic       rsr;
        logic       rtr;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dst;
    } stim_t;

    localparam logic [10:0] DEF      = 11'b11111_0000_00;
    localparam logic [10:0] EXC      = 11'b11111_1111_00;
    localparam logic [10:0] EXC_RUN  = 11'b11111_1111_10;
    localparam logic [10:0] DCB      = 11'b00001_0001_00;
    localparam logic [10:0] DCB_RUN  = 11'b00001_0001_10;
    localparam logic [10:0] DIVR     = 11'b00011_0010_10;
    localparam logic [10:0] LU       = 11'b00111_0100_00;
    localparam logic [10:0] IC       = 11'b01111_1000_00;
    localparam logic [10:0] BR       = 11'b11111_1000_00;
    localparam logic [10:0] DONE     = 11'b11111_0000_01;

    int unsigned vectors = 0;
    int unsigned errors  = 0;
    logic [10:0] sb [$];
    logic [10:0] got;
    logic [10:0] exp_v;

    function automatic logic [10:0] obs();
        return {bus.PC_Wr, bus.ID_Wr, bus.EXE_Wr, bus.MEM_Wr, bus.WB_Wr,
                bus.ID_Flush, bus.EXE_Flush, bus.MEM_Flush, bus.WB_Flush,
                bus.Div_Busy, bus.Div_Done};
    endfunction

    task automatic drive(input stim_t s);
        rst                = s.rst;
        bus.MEM_ExcValid   = s.exc;
        bus.DCache_Busy    = s.dcb;
        bus.ICache_Busy    = s.icb;
        bus.EXE_BranchMiss = s.br;
        bus.EXE_DivStart   = s.div;
        bus.EXE_IsLoad     = s.ld;
        bus.EXE_IsMFC0     = s.mfc0;
        bus.ID_RsRead      = s.rsr;
        bus.ID_RtRead      = s.rtr;
        bus.ID_rs          = s.rs;
        bus.ID_rt          = s.rt;
        bus.EXE_Dst        = s.dst;
    endtask

    task automatic test_reset();
        stim_t s;
        s = '0;
        s.rst = 1'b1;
        s.div = 1'b1;
        drive(s);
        sb.push_back(DEF);
        @(negedge clk);
        got = obs();
        exp_v = sb.pop_front();
        vectors++;
        if (got !== exp_v) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, exp_v);
        end
        vectors++;
        if (bus.Stall_Cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", bus.Stall_Cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_load_use();
        stim_t s [7];
        logic [10:0] e [7];
        for (int i = 0; i < 7; i++) s[i] = '0;
        s[0].ld = 1'b1; s[0].dst = 5'd5; s[0].rs = 5'd5; s[0].rsr = 1'b1; e[0] = LU;
        e[1] = DEF;
        s[2].ld = 1'b1; s[2].dst = 5'd5; s[2].rs = 5'd5; e[2] = DEF;
        s[3].mfc0 = 1'b1; s[3].dst = 5'd9; s[3].rt = 5'd9; s[3].rtr = 1'b1; e[3] = LU;
        s[4].ld = 1'b1; s[4].rsr = 1'b1; e[4] = DEF;
        s[5].ld = 1'b1; s[5].dst = 5'd7; s[5].rs = 5'd6; s[5].rt = 5'd8;
        s[5].rsr = 1'b1; s[5].rtr = 1'b1; e[5] = DEF;
        s[6].dst = 5'd5; s[6].rs = 5'd5; s[6].rsr = 1'b1; e[6] = DEF;
        for (int i = 0; i < 7; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL load_use[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_priority();
        stim_t s [6];
        logic [10:0] e [6];
        stim_t all;
        all = '0;
        all.exc = 1'b1; all.dcb = 1'b1; all.icb = 1'b1; all.br = 1'b1;
        all.ld = 1'b1; all.dst = 5'd3; all.rs = 5'd3; all.rsr = 1'b1;
        s[0] = all;                                      e[0] = EXC;
        s[1] = all; s[1].exc = 1'b0;                     e[1] = DCB;
        s[2] = s[1]; s[2].dcb = 1'b0;                    e[2] = LU;
        s[3] = s[2]; s[3].ld = 1'b0;                     e[3] = IC;
        s[4] = s[3]; s[4].icb = 1'b0;                    e[4] = BR;
        s[5] = '0;                                       e[5] = DEF;
        for (int i = 0; i < 6; i++) begin
            drive(s[i]);
            sb.push_back(e[i]);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL priority[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Start pulse, 32 busy cycles, done strobe; a start during DIV_DONE is ignored.
    task automatic test_divide();
        stim_t s;
        for (int i = 0; i < 36; i++) begin
            s = '0;
            if (i == 0 || i == 33) s.div = 1'b1;
            drive(s);
            if (i == 0)       sb.push_back(DEF);
            else if (i <= 32) sb.push_back(DIVR);
            else if (i == 33) sb.push_back(DONE);
            else              sb.push_back(DEF);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL divide[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // D-cache stall for three cycles mid-divide stretches it to 35 busy cycles.
    task automatic test_div_dcache();
        stim_t s;
        for (int i = 0; i < 38; i++) begin
            s = '0;
            if (i == 0) s.div = 1'b1;
            if (i >= 11 && i <= 13) s.dcb = 1'b1;
            drive(s);
            if (i == 0)                  sb.push_back(DEF);
            else if (i >= 11 && i <= 13) sb.push_back(DCB_RUN);
            else if (i <= 35)            sb.push_back(DIVR);
            else if (i == 36)            sb.push_back(DONE);
            else                         sb.push_back(DEF);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL div_dcache[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Exception in the tenth busy cycle aborts the divide with no done strobe.
    task automatic test_div_exc();
        stim_t s;
        for (int i = 0; i < 14; i++) begin
            s = '0;
            if (i == 0) s.div = 1'b1;
            if (i == 10) s.exc = 1'b1;
            drive(s);
            if (i == 0)       sb.push_back(DEF);
            else if (i < 10)  sb.push_back(DIVR);
            else if (i == 10) sb.push_back(EXC_RUN);
            else              sb.push_back(DEF);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL div_exc[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Asynchronous reset mid-divide clears busy within the same cycle.
    task automatic test_reset_mid_div();
        stim_t s;
        for (int i = 0; i < 9; i++) begin
            s = '0;
            if (i == 0) s.div = 1'b1;
            if (i == 6) s.rst = 1'b1;
            drive(s);
            if (i == 0)      sb.push_back(DEF);
            else if (i <= 5) sb.push_back(DIVR);
            else             sb.push_back(DEF);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL reset_mid_div[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_stall_cnt();
        stim_t s;
        logic [31:0] exp_cnt;
`ifdef PIPE_STALL_CNT_EN
        exp_cnt = 32'd7;
`else
        exp_cnt = 32'd0;
`endif
        for (int i = 0; i < 8; i++) begin
            s = '0;
            if (i == 0) s.rst = 1'b1;
            else        s.icb = 1'b1;
            drive(s);
            sb.push_back(i == 0 ? DEF : IC);
            @(negedge clk);
            got = obs();
            exp_v = sb.pop_front();
            vectors++;
            if (got !== exp_v) begin
                errors++;
                $display("FAIL stall_cnt_cycle[%0d]: got %b expected %b", i, got, exp_v);
            end
            @(posedge clk);
            #1;
        end
        drive('0);
        @(negedge clk);
        vectors++;
        if (bus.Stall_Cnt !== exp_cnt) begin
            errors++;
            $display("FAIL stall_cnt_value: got %0d expected %0d", bus.Stall_Cnt, exp_cnt);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_priority();
        test_divide();
        test_div_dcache();
        test_div_exc();
        test_reset_mid_div();
        test_stall_cnt();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
